gpio_input_ctl: RTL and testbench
=================================

# gpio_input_ctl

Input conditioner for the raw board-level controls that steer the game. Synchronises and debounces player 2's left/right GPIO lines and the two pressure-plate buttons. It also arbitrates left/right into a single, mutually exclusive direction. Its outputs feed `gpio_left`, `gpio_right` and `button_pressed[1:0]` of the player movement controller directly, in the same `clk` domain.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 650000 (10 ms at 65 MHz): consecutive stable cycles required to accept a level change; legal range ≥ 2.

Ports:
- `clk`  in  1  system clock (65 MHz pixel clock domain).
- `rst`  in  1  reset, synchronous, active-high.
- `gpio_left_raw`  in  1  asynchronous raw left switch, active-high.
- `gpio_right_raw`  in  1  asynchronous raw right switch, active-high.
- `button_raw`  in  2  asynchronous raw plate buttons, active-high.
- `gpio_left`  out  1  registered arbitrated left command.
- `gpio_right`  out  1  registered arbitrated right command.
- `button_pressed`  out  2  registered debounced buttons.

## Operation
- Four identical channels, one each for `gpio_left_raw`, `gpio_right_raw`, `button_raw[0]` and `button_raw[1]`.
- **Synchroniser:** two-flop synchroniser per channel. `s` is the second flop.
- **Debouncer:**
  - Each channel holds a debounced level `d` and a counter `cnt` of width `$clog2(DEBOUNCE_CYCLES)`.
  - If `s == d`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `d <= s` and `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - Any glitch back to `d` clears the count; there is no partial credit.
- `button_pressed[i] = d` of button channel `i`, taken directly from its register.
- **Direction FSM** (states `DIR_IDLE`, `DIR_LEFT`, `DIR_RIGHT`), driven by the debounced `dl` and `dr`:
  - `DIR_IDLE`: `dl & !dr` goes to `DIR_LEFT`. `dr & !dl` goes to `DIR_RIGHT`. Both high or both low stay in `DIR_IDLE`.
  - `DIR_LEFT`: stay while `dl`, regardless of `dr` (first-come holds). On `!dl`, go to `DIR_RIGHT` if `dr`, otherwise to `DIR_IDLE`.
  - `DIR_RIGHT`: symmetric to `DIR_LEFT`.
  - Illegal state encoding goes to `DIR_IDLE`.
- Outputs are registered and decoded from the next state:
  - `gpio_left <= (state_nxt == DIR_LEFT)`.
  - `gpio_right <= (state_nxt == DIR_RIGHT)`.
- `gpio_left` and `gpio_right` are never high together.

## Timing
- **Reset:** all synchroniser flops, `d`, `cnt`, `gpio_left`, `gpio_right` and `button_pressed` are 0, and the FSM is in `DIR_IDLE`, from the first edge with `rst` high.
- **Reset mid-operation:**
  - Outputs drop to 0 on the next edge.
  - After release, an input held high needs the full latency again.
- **Latency from a clean raw edge (stable from edge 0):**
  - `s` changes after edge 2.
  - `d` and `button_pressed` change after edge 2+`DEBOUNCE_CYCLES`.
  - `gpio_left` / `gpio_right` change after edge 3+`DEBOUNCE_CYCLES`.
- Release has the same latency as press.
- **Pulse rejection:**
  - A raw pulse shorter than `DEBOUNCE_CYCLES` cycles, as seen at `s`, never reaches `d`.
  - A pulse of exactly `DEBOUNCE_CYCLES` cycles is accepted.
- **Simultaneous events:**
  - Both directions debounced on the same edge from `DIR_IDLE`: both outputs stay 0 until one of them releases.
  - Releasing the active direction while the other is held transfers the output in one cycle, with no gap cycle at 0.
- The counter never exceeds `DEBOUNCE_CYCLES-1`; there is no wrap-around.

## Test plan
Run with `DEBOUNCE_CYCLES = 4`:
- **Reset:**
  - Stimulus: raise `rst` for 3 cycles while all raw inputs are high.
  - Required: all outputs 0 throughout. After release, `gpio_left` is still 0 at edge 6 and 0 after edge 6, then rises after edge 7.
- **Press/release latency:**
  - Stimulus: `gpio_right_raw` goes 0→1 at edge 0 and is held.
  - Required: `gpio_right` is 1 after edge 7. Release at edge 20 gives `gpio_right` = 0 after edge 27.
- **Glitch rejection:**
  - Stimulus: pulse `button_raw[1]` high for 3 cycles.
  - Required: `button_pressed` stays 2'b00.
  - Stimulus: pulse it high for 4 cycles.
  - Required: `button_pressed` = 2'b10 for exactly 4 cycles, starting after edge 6.
- **Mid-count bounce:**
  - Stimulus: `gpio_left_raw` high for 3 cycles, low 1 cycle, then high held.
  - Required: `gpio_left` rises only after the 4th edge following the re-rise, plus 3.
- **Arbitration:**
  - Stimulus: `gpio_left_raw` and `gpio_right_raw` rise on the same edge.
  - Required: both outputs stay 0.
  - Stimulus: drop left.
  - Required: `gpio_right` = 1 after release latency 7.
  - Stimulus: with left already active, raise right.
  - Required: `gpio_left` stays 1 and `gpio_right` stays 0. On left release, `gpio_right` becomes 1 on the same edge `gpio_left` falls.
- **Invariant:**
  - Stimulus: random raw stimulus for 10,000 cycles.
  - Required: `gpio_left & gpio_right` is never 1.

Source files
------------

// File: rtl/gpio_input_ctl.sv
// gpio_input_ctl: synchronises and debounces the raw left/right GPIO lines and
// the two plate buttons, then arbitrates left/right into one exclusive
// direction command.
module gpio_input_ctl #(
    parameter int unsigned DEBOUNCE_CYCLES = 650000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       gpio_left_raw,
    input  logic       gpio_right_raw,
    input  logic [1:0] button_raw,
    output logic       gpio_left,
    output logic       gpio_right,
    output logic [1:0] button_pressed
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        DIR_IDLE  = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_RIGHT = 2'b10
    } dir_e;

    // Channel order: 0 = left, 1 = right, 2 = button 0, 3 = button 1.
    logic [3:0]         raw;
    logic [3:0]         meta_q, meta_d;
    logic [3:0]         sync_q, sync_d;
    logic [3:0]         deb_q, deb_d;
    logic [3:0][CW-1:0] cnt_q, cnt_d;
    dir_e               state_q, state_nxt;
    logic               gpio_left_q, gpio_left_d;
    logic               gpio_right_q, gpio_right_d;
    logic               dl, dr;

    assign raw = {button_raw, gpio_right_raw, gpio_left_raw};

    // Two-flop synchroniser chain for every channel.
    always_comb begin
        meta_d = raw;
        sync_d = meta_q;
    end

    // Debounce: accept a new level only after CNT_MAX+1 consecutive differing samples.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int unsigned i = 0; i < 4; i++) begin
            if (sync_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                deb_d[i] = sync_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    assign dl = deb_q[0];
    assign dr = deb_q[1];

    // Direction arbitration: first-come direction holds until it is released.
    always_comb begin
        state_nxt = DIR_IDLE;
        case (state_q)
            DIR_IDLE: begin
                if (dl && !dr)      state_nxt = DIR_LEFT;
                else if (dr && !dl) state_nxt = DIR_RIGHT;
                else                state_nxt = DIR_IDLE;
            end
            DIR_LEFT: begin
                if (dl)      state_nxt = DIR_LEFT;
                else if (dr) state_nxt = DIR_RIGHT;
                else         state_nxt = DIR_IDLE;
            end
            DIR_RIGHT: begin
                if (dr)      state_nxt = DIR_RIGHT;
                else if (dl) state_nxt = DIR_LEFT;
                else         state_nxt = DIR_IDLE;
            end
            default: state_nxt = DIR_IDLE;
        endcase
        gpio_left_d  = (state_nxt == DIR_LEFT);
        gpio_right_d = (state_nxt == DIR_RIGHT);
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q       <= '0;
            sync_q       <= '0;
            deb_q        <= '0;
            cnt_q        <= '0;
            state_q      <= DIR_IDLE;
            gpio_left_q  <= 1'b0;
            gpio_right_q <= 1'b0;
        end else begin
            meta_q       <= meta_d;
            sync_q       <= sync_d;
            deb_q        <= deb_d;
            cnt_q        <= cnt_d;
            state_q      <= state_nxt;
            gpio_left_q  <= gpio_left_d;
            gpio_right_q <= gpio_right_d;
        end
    end

    assign gpio_left      = gpio_left_q;
    assign gpio_right     = gpio_right_q;
    assign button_pressed = deb_q[3:2];

endmodule

// File: tb/tb_gpio_input_ctl.sv
// Scoreboard bench for gpio_input_ctl with DEBOUNCE_CYCLES = 4.
// Expected output vectors are {gpio_left, gpio_right, button_pressed[1:0]}.
module tb_gpio_input_ctl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       gpio_left_raw = 1'b0;
    logic       gpio_right_raw = 1'b0;
    logic [1:0] button_raw = 2'b00;
    logic       gpio_left;
    logic       gpio_right;
    logic [1:0] button_pressed;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [3:0] exp;
        logic [3:0] mask;
        bit         inv;
        string      name;
    } item_t;

    item_t sb[$];
    item_t it;

    gpio_input_ctl #(.DEBOUNCE_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .gpio_left_raw  (gpio_left_raw),
        .gpio_right_raw (gpio_right_raw),
        .button_raw     (button_raw),
        .gpio_left      (gpio_left),
        .gpio_right     (gpio_right),
        .button_pressed (button_pressed)
    );

    always #5 clk = ~clk;

    // Monitor: one output sample per cycle, checked against the queued expectation.
    always @(negedge clk) begin
        logic [3:0] act;
        if (sb.size() > 0) begin
            it  = sb.pop_front();
            act = {gpio_left, gpio_right, button_pressed};
            total++;
            if (it.inv) begin
                if ((gpio_left & gpio_right) !== 1'b0) begin
                    bad++;
                    $display("FAIL %s: left&right got %b want 0", it.name, gpio_left & gpio_right);
                end
            end else if ((act & it.mask) !== (it.exp & it.mask)) begin
                bad++;
                $display("FAIL %s: got %b want %b (mask %b) t=%0t", it.name, act, it.exp, it.mask, $time);
            end
        end
    end

    // Advance one edge and queue the outputs expected after it.
    task automatic tick(input logic [3:0] exp, input string nm);
        @(posedge clk);
        #1;
        sb.push_back('{exp, 4'hF, 1'b0, nm});
    endtask

    task automatic do_reset();
        gpio_left_raw  = 1'b0;
        gpio_right_raw = 1'b0;
        button_raw     = 2'b00;
        rst            = 1'b1;
        tick(4'b0000, "reset");
        tick(4'b0000, "reset");
        rst = 1'b0;
    endtask

    initial begin
        // Reset with all raw inputs high.
        gpio_left_raw  = 1'b1;
        gpio_right_raw = 1'b1;
        button_raw     = 2'b11;
        rst            = 1'b1;
        for (int k = 1; k <= 3; k++) tick(4'b0000, "reset_hold");
        rst            = 1'b0;
        gpio_right_raw = 1'b0;
        for (int k = 1; k <= 10; k++)
            tick({logic'(k >= 7), 1'b0, (k >= 6) ? 2'b11 : 2'b00}, "reset_release");

        // Mid-operation reset, then full latency again.
        rst = 1'b1;
        tick(4'b0000, "reset_mid");
        rst = 1'b0;
        for (int k = 1; k <= 8; k++)
            tick({logic'(k >= 7), 1'b0, (k >= 6) ? 2'b11 : 2'b00}, "reset_relatch");

        // Press / release latency on right.
        do_reset();
        gpio_right_raw = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick({1'b0, logic'(k >= 7 && k < 27), 2'b00}, "press_release");
            if (k == 20) gpio_right_raw = 1'b0;
        end

        // Three-cycle glitch rejected, four-cycle pulse accepted.
        do_reset();
        button_raw = 2'b10;
        for (int k = 1; k <= 12; k++) begin
            tick(4'b0000, "glitch3");
            if (k == 3) button_raw = 2'b00;
        end
        button_raw = 2'b10;
        for (int k = 1; k <= 14; k++) begin
            tick({2'b00, (k >= 6 && k < 10) ? 2'b10 : 2'b00}, "pulse4");
            if (k == 4) button_raw = 2'b00;
        end

        // Mid-count bounce restarts the count.
        do_reset();
        gpio_left_raw = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick({logic'(k >= 11), 3'b000}, "bounce");
            if (k == 3) gpio_left_raw = 1'b0;
            if (k == 4) gpio_left_raw = 1'b1;
        end

        // Simultaneous rise: neither wins until left drops.
        do_reset();
        gpio_left_raw  = 1'b1;
        gpio_right_raw = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick({1'b0, logic'(k >= 17), 2'b00}, "arb_both");
            if (k == 10) gpio_left_raw = 1'b0;
        end

        // Left holds against right, then hands over without a gap.
        do_reset();
        gpio_left_raw = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick({logic'(k >= 7 && k < 27), logic'(k >= 27), 2'b00}, "arb_hold");
            if (k == 10) gpio_right_raw = 1'b1;
            if (k == 20) gpio_left_raw = 1'b0;
        end

        // Random stimulus: outputs never both high.
        do_reset();
        for (int n = 0; n < 10000; n++) begin
            @(posedge clk);
            #1;
            sb.push_back('{4'b0000, 4'b0000, 1'b1, "invariant"});
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: gpio_left_raw  = ~gpio_left_raw;
                    1: gpio_right_raw = ~gpio_right_raw;
                    2: button_raw[0]  = ~button_raw[0];
                    default: button_raw[1] = ~button_raw[1];
                endcase
            end
        end

        // Drain the scoreboard within a bounded number of cycles.
        for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            bad++;
            $display("FAIL drain: pending %0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
